cmem_arbiter: RTL and testbench



---
 rtl/cmem_arbiter.sv | 145 ++++++++++++++
 tb/tb_cmem_arbiter.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmem_arbiter.sv
// Two-to-one round-robin arbiter merging the instruction (a) and data (b) cmem ports
// onto one shared pmem port, with one transaction outstanding at a time.
module cmem_arbiter #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned BE_WIDTH = WIDTH / 8
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                cmem_read_a_i,
    input  logic                cmem_write_a_i,
    input  logic [BE_WIDTH-1:0] cmem_byte_enable_a_i,
    input  logic [WIDTH-1:0]    cmem_address_a_i,
    input  logic [WIDTH-1:0]    cmem_wdata_a_i,
    output logic                cmem_resp_a_o,
    output logic [WIDTH-1:0]    cmem_rdata_a_o,

    input  logic                cmem_read_b_i,
    input  logic                cmem_write_b_i,
    input  logic [BE_WIDTH-1:0] cmem_byte_enable_b_i,
    input  logic [WIDTH-1:0]    cmem_address_b_i,
    input  logic [WIDTH-1:0]    cmem_wdata_b_i,
    output logic                cmem_resp_b_o,
    output logic [WIDTH-1:0]    cmem_rdata_b_o,

    output logic                pmem_read_o,
    output logic                pmem_write_o,
    output logic [BE_WIDTH-1:0] pmem_byte_enable_o,
    output logic [WIDTH-1:0]    pmem_address_o,
    output logic [WIDTH-1:0]    pmem_wdata_o,
    input  logic                pmem_resp_i,
    input  logic [WIDTH-1:0]    pmem_rdata_i
);

    typedef enum logic [1:0] {StIdle, StBusyA, StBusyB, StResp} state_e;

    state_e              state_q, state_d;
    logic                last_b_q, last_b_d;
    logic                req_read_q, req_read_d;
    logic                req_write_q, req_write_d;
    logic [BE_WIDTH-1:0] req_be_q, req_be_d;
    logic [WIDTH-1:0]    req_addr_q, req_addr_d;
    logic [WIDTH-1:0]    req_wdata_q, req_wdata_d;
    logic [WIDTH-1:0]    rdata_a_q, rdata_a_d;
    logic [WIDTH-1:0]    rdata_b_q, rdata_b_d;

    logic req_a, req_b, grant_b, busy;

    assign req_a = cmem_read_a_i | cmem_write_a_i;
    assign req_b = cmem_read_b_i | cmem_write_b_i;
    // On a tie, b wins unless b was the last port served.
    assign grant_b = req_b & (~req_a | ~last_b_q);

    always_comb begin
        state_d     = state_q;
        last_b_d    = last_b_q;
        req_read_d  = req_read_q;
        req_write_d = req_write_q;
        req_be_d    = req_be_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        rdata_a_d   = rdata_a_q;
        rdata_b_d   = rdata_b_q;

        unique case (state_q)
            StIdle: begin
                if (req_a || req_b) begin
                    if (grant_b) begin
                        // A simultaneous read and write is issued as a write.
                        req_write_d = cmem_write_b_i;
                        req_read_d  = cmem_read_b_i & ~cmem_write_b_i;
                        req_be_d    = cmem_byte_enable_b_i;
                        req_addr_d  = cmem_address_b_i;
                        req_wdata_d = cmem_wdata_b_i;
                        state_d     = StBusyB;
                    end else begin
                        req_write_d = cmem_write_a_i;
                        req_read_d  = cmem_read_a_i & ~cmem_write_a_i;
                        req_be_d    = cmem_byte_enable_a_i;
                        req_addr_d  = cmem_address_a_i;
                        req_wdata_d = cmem_wdata_a_i;
                        state_d     = StBusyA;
                    end
                end
            end
            StBusyA, StBusyB: begin
                if (pmem_resp_i) begin
                    if (req_read_q) begin
                        if (state_q == StBusyB) begin
                            rdata_b_d = pmem_rdata_i;
                        end else begin
                            rdata_a_d = pmem_rdata_i;
                        end
                    end
                    last_b_d = (state_q == StBusyB);
                    state_d  = StResp;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            last_b_q    <= 1'b0;
            req_read_q  <= 1'b0;
            req_write_q <= 1'b0;
            req_be_q    <= '0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            rdata_a_q   <= '0;
            rdata_b_q   <= '0;
        end else begin
            state_q     <= state_d;
            last_b_q    <= last_b_d;
            req_read_q  <= req_read_d;
            req_write_q <= req_write_d;
            req_be_q    <= req_be_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            rdata_a_q   <= rdata_a_d;
            rdata_b_q   <= rdata_b_d;
        end
    end

    assign busy = (state_q == StBusyA) || (state_q == StBusyB);

    // During RESP the last-grant flag already names the port being answered.
    assign pmem_read_o        = busy & req_read_q;
    assign pmem_write_o       = busy & req_write_q;
    assign pmem_byte_enable_o = req_be_q;
    assign pmem_address_o     = req_addr_q;
    assign pmem_wdata_o       = req_wdata_q;
    assign cmem_resp_a_o      = (state_q == StResp) & ~last_b_q;
    assign cmem_resp_b_o      = (state_q == StResp) & last_b_q;
    assign cmem_rdata_a_o     = rdata_a_q;
    assign cmem_rdata_b_o     = rdata_b_q;

endmodule

// File: tb/tb_cmem_arbiter.sv
// Randomized scoreboard bench for cmem_arbiter: requester drivers push expected transactions,
// a negedge monitor predicts grants, pmem traffic and responses from the arbitration rules.
module tb_cmem_arbiter;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    localparam int PhIdle = 0;
    localparam int PhBusy = 1;
    localparam int PhResp = 2;

    logic        clk, rst_n;
    logic        rd_a, wr_a, rd_b, wr_b;
    logic [3:0]  be_a, be_b;
    logic [31:0] addr_a, wdata_a, addr_b, wdata_b;
    logic        resp_a, resp_b;
    logic [31:0] rdata_a, rdata_b;
    logic        pmem_read, pmem_write, pmem_resp;
    logic [3:0]  pmem_be;
    logic [31:0] pmem_address, pmem_wdata, pmem_rdata;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    txn_t q_a[$];
    txn_t q_b[$];
    bit   granted_a, granted_b;

    int  mem_lat_fixed;
    bit  mem_noise_req;
    bit  mem_busy;
    int  mem_cnt;

    cmem_arbiter u_dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .cmem_read_a_i        (rd_a),
        .cmem_write_a_i       (wr_a),
        .cmem_byte_enable_a_i (be_a),
        .cmem_address_a_i     (addr_a),
        .cmem_wdata_a_i       (wdata_a),
        .cmem_resp_a_o        (resp_a),
        .cmem_rdata_a_o       (rdata_a),
        .cmem_read_b_i        (rd_b),
        .cmem_write_b_i       (wr_b),
        .cmem_byte_enable_b_i (be_b),
        .cmem_address_b_i     (addr_b),
        .cmem_wdata_b_i       (wdata_b),
        .cmem_resp_b_o        (resp_b),
        .cmem_rdata_b_o       (rdata_b),
        .pmem_read_o          (pmem_read),
        .pmem_write_o         (pmem_write),
        .pmem_byte_enable_o   (pmem_be),
        .pmem_address_o       (pmem_address),
        .pmem_wdata_o         (pmem_wdata),
        .pmem_resp_i          (pmem_resp),
        .pmem_rdata_i         (pmem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_port(input bit pb, input logic rd, input logic wr, input logic [3:0] be,
                            input logic [31:0] addr, input logic [31:0] wdata);
        if (pb) begin
            rd_b = rd; wr_b = wr; be_b = be; addr_b = addr; wdata_b = wdata;
        end else begin
            rd_a = rd; wr_a = wr; be_a = be; addr_a = addr; wdata_a = wdata;
        end
    endtask

    task automatic drive_port(input bit pb, input int ntx);
        txn_t t;
        bit   got;
        bit   in_rd, in_wr;
        int   sel;
        for (int n = 0; n < ntx; n++) begin
            @(posedge clk); #1;
            set_port(pb, 1'b0, 1'b0, 4'($urandom), $urandom, $urandom);
            if (n != 0) begin
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk); #1;
                end
            end
            sel     = int'($urandom_range(0, 3));
            in_rd   = (sel != 1);
            in_wr   = (sel == 1) || (sel == 2);
            t.rd    = in_rd && !in_wr;
            t.wr    = in_wr;
            t.be    = 4'($urandom);
            t.addr  = $urandom;
            t.wdata = $urandom;
            if (pb) granted_b = 1'b0; else granted_a = 1'b0;
            if (pb) q_b.push_back(t); else q_a.push_back(t);
            set_port(pb, in_rd, in_wr, t.be, t.addr, t.wdata);
            got = 1'b0;
            for (int w = 0; w < 60 && !got; w++) begin
                @(negedge clk);
                if (pb ? resp_b : resp_a) begin
                    got = 1'b1;
                end else if (pb ? granted_b : granted_a) begin
                    // Inputs are free to wander once the request has been latched.
                    @(posedge clk); #1;
                    set_port(pb, ($urandom_range(0, 3) != 0) ? in_rd : 1'b0, in_wr,
                             4'($urandom), $urandom, $urandom);
                end
            end
            chk(pb ? "resp_timeout_b" : "resp_timeout_a", 32'(got), 32'd1);
        end
        @(posedge clk); #1;
        set_port(pb, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    // Shared memory model with random latency and stray resp pulses while no request is up.
    initial begin
        pmem_resp  = 1'b0;
        pmem_rdata = 32'h0;
        mem_busy   = 1'b0;
        mem_cnt    = 0;
        forever begin
            @(posedge clk); #1;
            pmem_resp = 1'b0;
            if (!rst_n) begin
                mem_busy = 1'b0;
            end else begin
                if (!mem_busy && (pmem_read || pmem_write)) begin
                    mem_busy = 1'b1;
                    mem_cnt  = (mem_lat_fixed >= 0) ? mem_lat_fixed : int'($urandom_range(0, 5));
                end
                if (mem_busy) begin
                    if (mem_cnt == 0) begin
                        pmem_resp  = 1'b1;
                        pmem_rdata = $urandom;
                        mem_busy   = 1'b0;
                    end else begin
                        mem_cnt--;
                    end
                end else if (!(pmem_read || pmem_write) &&
                             (mem_noise_req || $urandom_range(0, 7) == 0)) begin
                    pmem_resp     = 1'b1;
                    pmem_rdata    = $urandom;
                    mem_noise_req = 1'b0;
                end
            end
        end
    end

    // Reference model: IDLE grants, BUSY holds fields until pmem_resp, RESP pulses one cycle.
    initial begin
        int          m_ph;
        bit          m_port_b, m_last_b, ra, rb;
        txn_t        m_cur;
        logic [31:0] m_rdata_a, m_rdata_b;
        m_ph = PhIdle; m_port_b = 1'b0; m_last_b = 1'b0; m_cur = '0;
        m_rdata_a = 32'h0; m_rdata_b = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_pmem_read", 32'(pmem_read), 32'd0);
                chk("rst_pmem_write", 32'(pmem_write), 32'd0);
                chk("rst_pmem_be", 32'(pmem_be), 32'd0);
                chk("rst_pmem_address", pmem_address, 32'd0);
                chk("rst_pmem_wdata", pmem_wdata, 32'd0);
                chk("rst_resp_a", 32'(resp_a), 32'd0);
                chk("rst_resp_b", 32'(resp_b), 32'd0);
                chk("rst_rdata_a", rdata_a, 32'd0);
                chk("rst_rdata_b", rdata_b, 32'd0);
                m_ph = PhIdle; m_last_b = 1'b0; m_rdata_a = 32'h0; m_rdata_b = 32'h0;
                q_a.delete();
                q_b.delete();
            end else begin
                chk("rdata_a", rdata_a, m_rdata_a);
                chk("rdata_b", rdata_b, m_rdata_b);
                chk("resp_a", 32'(resp_a), 32'(m_ph == PhResp && !m_port_b));
                chk("resp_b", 32'(resp_b), 32'(m_ph == PhResp && m_port_b));
                if (m_ph == PhBusy) begin
                    chk("pmem_read", 32'(pmem_read), 32'(m_cur.rd));
                    chk("pmem_write", 32'(pmem_write), 32'(m_cur.wr));
                    chk("pmem_be", 32'(pmem_be), 32'(m_cur.be));
                    chk("pmem_address", pmem_address, m_cur.addr);
                    chk("pmem_wdata", pmem_wdata, m_cur.wdata);
                end else begin
                    chk("idle_pmem_read", 32'(pmem_read), 32'd0);
                    chk("idle_pmem_write", 32'(pmem_write), 32'd0);
                end
                case (m_ph)
                    PhIdle: begin
                        ra = rd_a || wr_a;
                        rb = rd_b || wr_b;
                        if (ra || rb) begin
                            m_port_b = rb && (!ra || !m_last_b);
                            if (m_port_b) begin
                                chk("grant_queue_b", 32'(q_b.size()), 32'd1);
                                if (q_b.size() != 0) m_cur = q_b.pop_front();
                                granted_b = 1'b1;
                            end else begin
                                chk("grant_queue_a", 32'(q_a.size()), 32'd1);
                                if (q_a.size() != 0) m_cur = q_a.pop_front();
                                granted_a = 1'b1;
                            end
                            m_ph = PhBusy;
                        end
                    end
                    PhBusy: begin
                        if (pmem_resp) begin
                            if (m_cur.rd) begin
                                if (m_port_b) m_rdata_b = pmem_rdata;
                                else m_rdata_a = pmem_rdata;
                            end
                            m_last_b = m_port_b;
                            m_ph     = PhResp;
                        end
                    end
                    default: m_ph = PhIdle;
                endcase
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t t;
        bit   got;
        rst_n = 1'b0;
        mem_lat_fixed = -1;
        mem_noise_req = 1'b0;
        granted_a = 1'b0;
        granted_b = 1'b0;
        set_port(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        set_port(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("init_pmem_read", 32'(pmem_read), 32'd0);
        chk("init_resp_a", 32'(resp_a), 32'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;

        fork
            drive_port(1'b0, 60);
            drive_port(1'b1, 60);
        join

        // Reset while a write on b is in flight; read_b is ignored because write wins.
        repeat (3) @(posedge clk);
        #1;
        mem_lat_fixed = 5;
        t = '{rd: 1'b0, wr: 1'b1, be: 4'b0011, addr: 32'h40, wdata: 32'h1234_5678};
        granted_b = 1'b0;
        q_b.push_back(t);
        set_port(1'b1, 1'b1, 1'b1, t.be, t.addr, t.wdata);
        for (int i = 0; i < 10 && !pmem_write; i++) @(negedge clk);
        chk("rst_test_busy", 32'(pmem_write), 32'd1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_pmem_write", 32'(pmem_write), 32'd0);
        chk("async_rst_pmem_address", pmem_address, 32'd0);
        chk("async_rst_pmem_wdata", pmem_wdata, 32'd0);
        chk("async_rst_pmem_be", 32'(pmem_be), 32'd0);
        chk("async_rst_resp_b", 32'(resp_b), 32'd0);
        set_port(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        mem_noise_req = 1'b1;
        repeat (6) @(posedge clk);

        // Service resumes normally after the aborted transaction.
        #1;
        mem_lat_fixed = 1;
        t = '{rd: 1'b1, wr: 1'b0, be: 4'hf, addr: 32'h100, wdata: 32'h0};
        granted_a = 1'b0;
        q_a.push_back(t);
        set_port(1'b0, 1'b1, 1'b0, t.be, t.addr, t.wdata);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (resp_a) got = 1'b1;
        end
        chk("post_rst_read_resp_a", 32'(got), 32'd1);
        @(posedge clk); #1;
        set_port(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        repeat (4) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
